// File: rtl/alu_pipe_if.sv
// alu_pipe_if: valid/ready operation and result bus of the EX-stage ALU
interface alu_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] first;
    logic [WIDTH-1:0] second;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero_flag;
    logic             carry_flag;
    logic             ovf_flag;
    logic             neg_flag;
    logic             illegal_op;
    modport master (
        output in_valid, op, first, second, out_ready,
        input  in_ready, out_valid, result, zero_flag, carry_flag, ovf_flag, neg_flag, illegal_op
    );
    modport slave (
        input  in_valid, op, first, second, out_ready,
        output in_ready, out_valid, result, zero_flag, carry_flag, ovf_flag, neg_flag, illegal_op
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked EX-stage ALU with registered result/flags; ALU_MUL_EN adds opcode 1101 iterative multiply
module alu_pipe #(
    parameter int WIDTH = 16
) (
    input logic       clk,
    input logic       rst_n,
    alu_pipe_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
    state_t state, next_state;
    logic [WIDTH-1:0] res_q, alu_r;
    logic [WIDTH:0] sum, diff;
    logic [SHAMT_W-1:0] shamt;
    logic zero_q, carry_q, ovf_q, neg_q, ill_q;
    logic alu_c, alu_v, alu_ill, accept, is_mul, done;
    assign sum = {1'b0, bus.first} + {1'b0, bus.second};
    assign diff = {1'b0, bus.first} - {1'b0, bus.second};
    assign shamt = bus.second[SHAMT_W-1:0];
    assign bus.in_ready = (state == IDLE) || (state == HOLD && bus.out_ready);
    assign accept = bus.in_valid && bus.in_ready;
    assign bus.out_valid = state == HOLD;
    assign bus.result = res_q;
    assign bus.zero_flag = zero_q;
    assign bus.carry_flag = carry_q;
    assign bus.ovf_flag = ovf_q;
    assign bus.neg_flag = neg_q;
    assign bus.illegal_op = ill_q;
`ifdef ALU_MUL_EN
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0] acc, mcand, mplier, addend;
    assign is_mul = bus.op == 4'hd;
    assign done = cnt == SHAMT_W'(WIDTH - 1);
    assign addend = mplier[0] ? mcand : '0;
    // shift-add multiplier: one partial product per BUSY cycle, operands latched at acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            acc <= '0;
            mcand <= '0;
            mplier <= '0;
        end else if (accept && is_mul) begin
            cnt <= '0;
            acc <= '0;
            mcand <= bus.first;
            mplier <= bus.second;
        end else if (state == BUSY) begin
            cnt <= cnt + 1'b1;
            acc <= acc + addend;
            mcand <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end
`else
    assign is_mul = 1'b0;
    assign done = 1'b0;
`endif
    // single-cycle datapath; 1101 lands in default (illegal) unless the multiplier is built
    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        alu_ill = 1'b0;
        case (bus.op)
            4'h0: begin
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (bus.first[WIDTH-1] == bus.second[WIDTH-1]) && (sum[WIDTH-1] != bus.first[WIDTH-1]);
            end
            4'h1: begin
                alu_r = diff[WIDTH-1:0];
                alu_c = diff[WIDTH];
                alu_v = (bus.first[WIDTH-1] != bus.second[WIDTH-1]) && (diff[WIDTH-1] != bus.first[WIDTH-1]);
            end
            4'h2: alu_r = bus.first & bus.second;
            4'h3: alu_r = bus.first | bus.second;
            4'h4: alu_r = ~bus.first;
            4'h5: alu_r = $signed(bus.first) >>> shamt;
            4'h6: alu_r = bus.first << shamt;
            4'h7: alu_r = {{(WIDTH-1){1'b0}}, $signed(bus.first) < $signed(bus.second)};
            4'h8: alu_r = '0;
            4'h9: alu_r = bus.first;
            4'ha: alu_r = {{(WIDTH-1){1'b0}}, bus.first == '0};
            4'hb: alu_r = {{(WIDTH-1){1'b0}}, bus.first != bus.second};
            4'hc: alu_r = bus.second;
`ifdef ALU_MUL_EN
            4'hd: alu_r = '0;
`endif
            default: alu_ill = 1'b1;
        endcase
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= next_state;
    end
    // next state: accepted op wins, otherwise drain HOLD or finish BUSY
    always_comb begin
        next_state = state;
        if (accept) next_state = is_mul ? BUSY : HOLD;
        else if (state == HOLD && bus.out_ready) next_state = IDLE;
        else if (state == BUSY && done) next_state = HOLD;
    end
    // output register: loads on single-cycle acceptance or multiply completion, else holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            zero_q <= 1'b0;
            carry_q <= 1'b0;
            ovf_q <= 1'b0;
            neg_q <= 1'b0;
            ill_q <= 1'b0;
        end else if (accept && !is_mul) begin
            res_q <= alu_r;
            zero_q <= alu_r == '0;
            carry_q <= alu_c;
            ovf_q <= alu_v;
            neg_q <= alu_r[WIDTH-1];
            ill_q <= alu_ill;
`ifdef ALU_MUL_EN
        end else if (state == BUSY && done) begin
            res_q <= acc + addend;
            zero_q <= (acc + addend) == '0;
            carry_q <= 1'b0;
            ovf_q <= 1'b0;
            neg_q <= (acc[WIDTH-1:0] + addend) >> (WIDTH - 1) != '0;
            ill_q <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors with hand-computed results for alu_pipe (WIDTH=16)
module tb_alu_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    alu_pipe_if #(.WIDTH(16)) bus ();
    alu_pipe #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic expect_out(input string tag, input logic [15:0] r, input logic [4:0] f);
        check({tag, "/res"}, bus.result, r);
        check({tag, "/zcvni"}, {11'b0, bus.zero_flag, bus.carry_flag, bus.ovf_flag, bus.neg_flag, bus.illegal_op}, {11'b0, f});
    endtask
    task automatic issue(input string tag, input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] r, input logic [4:0] f);
        bus.in_valid = 1'b1;
        bus.op = o;
        bus.first = a;
        bus.second = b;
        check({tag, "/rdy"}, {15'b0, bus.in_ready}, 16'h1);
        tick();
        bus.in_valid = 1'b0;
        bus.first = 16'hdead;
        bus.second = 16'hbeef;
        check({tag, "/vld"}, {15'b0, bus.out_valid}, 16'h1);
        expect_out(tag, r, f);
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.op = 4'h0;
        bus.first = '0;
        bus.second = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("rst/vld", {15'b0, bus.out_valid}, 16'h0);
        expect_out("rst", 16'h0000, 5'b00000);
        rst_n = 1'b1;
        tick();
        check("rst/rdy", {15'b0, bus.in_ready}, 16'h1);
        issue("add_wrap", 4'h0, 16'hffff, 16'h0001, 16'h0000, 5'b11000);
        issue("sub_ovf", 4'h1, 16'h8000, 16'h0001, 16'h7fff, 5'b00100);
        issue("sub_brw", 4'h1, 16'h0001, 16'h0002, 16'hffff, 5'b01010);
        issue("add_ovf", 4'h0, 16'h7fff, 16'h0001, 16'h8000, 5'b00110);
        issue("sra", 4'h5, 16'h8000, 16'h0004, 16'hf800, 5'b00010);
        issue("sra_mask", 4'h5, 16'h8000, 16'h0014, 16'hf800, 5'b00010);
        issue("sll", 4'h6, 16'h0001, 16'h000f, 16'h8000, 5'b00010);
        issue("sll_mask", 4'h6, 16'h0003, 16'h0010, 16'h0003, 5'b00000);
        issue("slt_t", 4'h7, 16'hffff, 16'h0001, 16'h0001, 5'b00000);
        issue("slt_f", 4'h7, 16'h0001, 16'hffff, 16'h0000, 5'b10000);
        issue("and", 4'h2, 16'hf0f0, 16'hff00, 16'hf000, 5'b00010);
        issue("or", 4'h3, 16'h0f00, 16'h00f0, 16'h0ff0, 5'b00000);
        issue("not", 4'h4, 16'h00ff, 16'h1234, 16'hff00, 5'b00010);
        issue("zero", 4'h8, 16'h1234, 16'h5678, 16'h0000, 5'b10000);
        issue("passa", 4'h9, 16'h1234, 16'h5678, 16'h1234, 5'b00000);
        issue("lnot0", 4'ha, 16'h0000, 16'h5678, 16'h0001, 5'b00000);
        issue("lnot5", 4'ha, 16'h0005, 16'h5678, 16'h0000, 5'b10000);
        issue("neq_eq", 4'hb, 16'h0005, 16'h0005, 16'h0000, 5'b10000);
        issue("neq_ne", 4'hb, 16'h0005, 16'h0006, 16'h0001, 5'b00000);
        issue("passb", 4'hc, 16'h0000, 16'h5678, 16'h5678, 5'b00000);
        issue("ill_f", 4'hf, 16'h1234, 16'h0000, 16'h0000, 5'b10001);
        issue("ill_e", 4'he, 16'h1234, 16'h0001, 16'h0000, 5'b10001);
`ifdef ALU_MUL_EN
        begin
            int n;
            bus.in_valid = 1'b1;
            bus.op = 4'hd;
            bus.first = 16'h0012;
            bus.second = 16'h0034;
            tick();
            bus.in_valid = 1'b0;
            bus.first = 16'hffff;
            bus.second = 16'hffff;
            n = 0;
            while (!bus.out_valid && n < 40) begin
                check("mul/busy_rdy", {15'b0, bus.in_ready}, 16'h0);
                tick();
                n++;
            end
            check("mul/cycles", 16'(n), 16'd16);
            expect_out("mul", 16'h03a8, 5'b00000);
        end
`else
        issue("mul_ill", 4'hd, 16'h0012, 16'h0034, 16'h0000, 5'b10001);
`endif
        tick();
        check("drain/vld", {15'b0, bus.out_valid}, 16'h0);
        bus.out_ready = 1'b0;
        issue("bp_add", 4'h0, 16'h0003, 16'h0004, 16'h0007, 5'b00000);
        bus.in_valid = 1'b1;
        bus.op = 4'h3;
        bus.first = 16'h00f0;
        bus.second = 16'h000f;
        for (int i = 0; i < 3; i++) begin
            check("bp/rdy", {15'b0, bus.in_ready}, 16'h0);
            tick();
            check("bp/vld", {15'b0, bus.out_valid}, 16'h1);
            expect_out("bp_hold", 16'h0007, 5'b00000);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp/rdy_rel", {15'b0, bus.in_ready}, 16'h1);
        tick();
        bus.in_valid = 1'b0;
        expect_out("bp_or", 16'h00ff, 5'b00000);
        tick();
        check("bp/idle", {15'b0, bus.out_valid}, 16'h0);
`ifdef ALU_MUL_EN
        bus.in_valid = 1'b1;
        bus.op = 4'hd;
        bus.first = 16'h0003;
        bus.second = 16'h0005;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
`else
        bus.out_ready = 1'b0;
        issue("pre_rst", 4'h0, 16'h0001, 16'h0001, 16'h0002, 5'b00000);
`endif
        rst_n = 1'b0;
        #1;
        check("arst/vld", {15'b0, bus.out_valid}, 16'h0);
        expect_out("arst", 16'h0000, 5'b00000);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("arst/rdy", {15'b0, bus.in_ready}, 16'h1);
        tick();
        check("arst/stay", {15'b0, bus.out_valid}, 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
